// File: rtl/remote_comm.sv
// remote_comm : host-side end of the BLE command link.
//
// Serializes an 8-bit command and a 16-bit data word as three back-to-back
// 8N1 UART frames on TX, in the order cmd, data[15:8], data[7:0]. Independently
// receives the quad's single-byte response on RX and holds it with a ready flag.
//
// Ports:
//   clk          system clock (50MHz)
//   rst_n        asynchronous active-low reset
//   snd_cmd      single-cycle request to transmit cmd/data (ignored while busy)
//   cmd          command byte, captured on an accepted snd_cmd
//   data         data word, captured on an accepted snd_cmd
//   RX           serial response from the quad (idle high, asynchronous)
//   TX           serial command to the quad (idle high)
//   busy         high while a 3-byte transmission is in progress
//   cmd_sent     one-cycle pulse when the third frame's stop bit completes
//   resp         last received response byte
//   resp_rdy     high while resp holds an unconsumed byte
//   clr_resp_rdy clears resp_rdy
//
// Transmit timing, with cycle 0 being the cycle snd_cmd is high:
//   cycle 1            LOAD (frame for byte 0 is built)
//   cycle 2            start bit of byte 0 appears on TX
//   byte k start       cycle 2 + k*(10*BAUD_DIV + 1)  (one LOAD cycle between frames)
//   cmd_sent / !busy   cycle 30*BAUD_DIV + 4
module remote_comm #(
   parameter int BAUD_DIV = 2604
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        snd_cmd,
   input  logic [7:0]  cmd,
   input  logic [15:0] data,
   input  logic        RX,
   output logic        TX,
   output logic        busy,
   output logic        cmd_sent,
   output logic [7:0]  resp,
   output logic        resp_rdy,
   input  logic        clr_resp_rdy
);

   localparam int CW = $clog2(BAUD_DIV + 1);
   localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
   localparam logic [CW-1:0] BAUD_ONE  = CW'(1);

   typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_SHIFT} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   // ---------------- transmit side ----------------
   tx_state_t       tx_state_q, tx_state_d;
   logic [23:0]     shadow_q, shadow_d;
   logic [1:0]      idx_q, idx_d;
   logic [9:0]      frame_q, frame_d;
   logic [CW-1:0]   tx_baud_q, tx_baud_d;
   logic [3:0]      tx_bit_q, tx_bit_d;
   logic            tx_q, tx_d;
   logic            busy_q, busy_d;
   logic            cmd_sent_q, cmd_sent_d;

   logic            snd_accept;
   logic            tx_bit_end;
   logic            tx_frame_end;
   logic [7:0]      cur_byte;

   // ---------------- receive side ----------------
   rx_state_t       rx_state_q, rx_state_d;
   logic            sync1_q, sync2_q, prev_q;
   logic [CW-1:0]   rx_baud_q, rx_baud_d;
   logic [3:0]      rx_bit_q, rx_bit_d;
   logic [7:0]      rx_shift_q, rx_shift_d;
   logic [7:0]      resp_q, resp_d;
   logic            resp_rdy_q, resp_rdy_d;

   logic            rx_fall;
   logic            rx_set;

   // A request is only honoured when the transmitter is idle; this also
   // serves as the "accepted snd_cmd" that clears resp_rdy.
   assign snd_accept   = snd_cmd && (tx_state_q == TX_IDLE);
   assign tx_bit_end   = (tx_baud_q == BAUD_LAST);
   assign tx_frame_end = tx_bit_end && (tx_bit_q == 4'd9);

   always_comb begin
      case (idx_q)
         2'd0:    cur_byte = shadow_q[23:16];
         2'd1:    cur_byte = shadow_q[15:8];
         default: cur_byte = shadow_q[7:0];
      endcase
   end

   // Transmit state register and datapath flops. TX is registered so the
   // line is glitch-free, and reset forces it high at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state_q <= TX_IDLE;
         shadow_q   <= '0;
         idx_q      <= '0;
         frame_q    <= '1;
         tx_baud_q  <= '0;
         tx_bit_q   <= '0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         cmd_sent_q <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         shadow_q   <= shadow_d;
         idx_q      <= idx_d;
         frame_q    <= frame_d;
         tx_baud_q  <= tx_baud_d;
         tx_bit_q   <= tx_bit_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         cmd_sent_q <= cmd_sent_d;
      end
   end

   // Transmit next-state logic.
   always_comb begin
      tx_state_d = tx_state_q;
      case (tx_state_q)
         TX_IDLE:  if (snd_accept) tx_state_d = TX_LOAD;
         TX_LOAD:  tx_state_d = TX_SHIFT;
         TX_SHIFT: if (tx_frame_end) tx_state_d = (idx_q == 2'd2) ? TX_IDLE : TX_LOAD;
         default:  tx_state_d = TX_IDLE;
      endcase
   end

   // Transmit datapath. tx_q always mirrors frame_q[0]: LOAD drives the start
   // bit, and each bit boundary shifts the frame and drives the next bit.
   // busy and cmd_sent are updated on the same edge, so busy falls in the
   // cycle cmd_sent pulses.
   always_comb begin
      shadow_d   = shadow_q;
      idx_d      = idx_q;
      frame_d    = frame_q;
      tx_baud_d  = tx_baud_q;
      tx_bit_d   = tx_bit_q;
      tx_d       = tx_q;
      busy_d     = busy_q;
      cmd_sent_d = 1'b0;
      case (tx_state_q)
         TX_IDLE: begin
            tx_d = 1'b1;
            if (snd_accept) begin
               shadow_d = {cmd, data};
               idx_d    = 2'd0;
               busy_d   = 1'b1;
            end
         end
         TX_LOAD: begin
            frame_d   = {1'b1, cur_byte, 1'b0};
            tx_d      = 1'b0;
            tx_baud_d = '0;
            tx_bit_d  = '0;
         end
         TX_SHIFT: begin
            if (tx_bit_end) begin
               tx_baud_d = '0;
               if (tx_bit_q == 4'd9) begin
                  tx_d = 1'b1;
                  if (idx_q == 2'd2) begin
                     cmd_sent_d = 1'b1;
                     busy_d     = 1'b0;
                  end else begin
                     idx_d = idx_q + 2'd1;
                  end
               end else begin
                  tx_bit_d = tx_bit_q + 4'd1;
                  frame_d  = {1'b1, frame_q[9:1]};
                  tx_d     = frame_q[1];
               end
            end else begin
               tx_baud_d = tx_baud_q + BAUD_ONE;
            end
         end
         default: tx_d = 1'b1;
      endcase
   end

   assign TX       = tx_q;
   assign busy     = busy_q;
   assign cmd_sent = cmd_sent_q;

   // RX edge detect on the synchronized line; prev_q resets high so a line
   // held low through reset is not mistaken for a start edge.
   assign rx_fall = prev_q && !sync2_q;
   assign rx_set  = (rx_state_q == RX_STOP) && (rx_baud_q == BAUD_LAST);

   // Receive synchronizer, state register and datapath flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         prev_q     <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_baud_q  <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         resp_q     <= '0;
         resp_rdy_q <= 1'b0;
      end else begin
         sync1_q    <= RX;
         sync2_q    <= sync1_q;
         prev_q     <= sync2_q;
         rx_state_q <= rx_state_d;
         rx_baud_q  <= rx_baud_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         resp_q     <= resp_d;
         resp_rdy_q <= resp_rdy_d;
      end
   end

   // Receive next-state logic. START re-checks the line at mid start bit to
   // reject short low glitches.
   always_comb begin
      rx_state_d = rx_state_q;
      case (rx_state_q)
         RX_IDLE:  if (rx_fall) rx_state_d = RX_START;
         RX_START: if (rx_baud_q == HALF_LAST) rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
         RX_DATA:  if ((rx_baud_q == BAUD_LAST) && (rx_bit_q == 4'd7)) rx_state_d = RX_STOP;
         RX_STOP:  if (rx_baud_q == BAUD_LAST) rx_state_d = RX_IDLE;
         default:  rx_state_d = RX_IDLE;
      endcase
   end

   // Receive datapath. The stop bit is only waited out, not checked. A new
   // byte's set of resp_rdy wins over a same-cycle clear.
   always_comb begin
      rx_baud_d  = rx_baud_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      resp_d     = resp_q;
      resp_rdy_d = resp_rdy_q;
      case (rx_state_q)
         RX_IDLE: begin
            rx_baud_d = '0;
            rx_bit_d  = '0;
         end
         RX_START: begin
            rx_baud_d = (rx_baud_q == HALF_LAST) ? '0 : rx_baud_q + BAUD_ONE;
         end
         RX_DATA: begin
            if (rx_baud_q == BAUD_LAST) begin
               rx_baud_d  = '0;
               rx_shift_d = {sync2_q, rx_shift_q[7:1]};
               rx_bit_d   = rx_bit_q + 4'd1;
            end else begin
               rx_baud_d = rx_baud_q + BAUD_ONE;
            end
         end
         RX_STOP: begin
            if (rx_baud_q == BAUD_LAST) begin
               rx_baud_d = '0;
               resp_d    = rx_shift_q;
            end else begin
               rx_baud_d = rx_baud_q + BAUD_ONE;
            end
         end
         default: rx_baud_d = '0;
      endcase
      if (clr_resp_rdy || snd_accept) resp_rdy_d = 1'b0;
      if (rx_set) resp_rdy_d = 1'b1;
   end

   assign resp     = resp_q;
   assign resp_rdy = resp_rdy_q;

endmodule

// File: tb/tb_remote_comm.sv
// Testbench for remote_comm at BAUD_DIV=16. A background UART decoder turns
// the TX line into bytes; stimulus tasks push expected bytes to a scoreboard
// queue and each test task pops and compares them once the DUT has finished.
module tb_remote_comm;

   localparam int B = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        snd_cmd = 1'b0;
   logic [7:0]  cmd = '0;
   logic [15:0] data = '0;
   logic        RX = 1'b1;
   logic        clr_resp_rdy = 1'b0;
   logic        TX, busy, cmd_sent, resp_rdy;
   logic [7:0]  resp;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int sent_count = 0;

   logic [7:0] tx_exp[$];
   logic [7:0] tx_seen[$];
   bit         tx_good[$];
   int         tx_start[$];
   logic [7:0] rx_exp[$];

   remote_comm #(.BAUD_DIV(B)) dut (
      .clk(clk), .rst_n(rst_n), .snd_cmd(snd_cmd), .cmd(cmd), .data(data),
      .RX(RX), .TX(TX), .busy(busy), .cmd_sent(cmd_sent), .resp(resp),
      .resp_rdy(resp_rdy), .clr_resp_rdy(clr_resp_rdy)
   );

   // 10ns clock and a free-running posedge counter used as the time base.
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Counts every cmd_sent pulse.
   always @(negedge clk) if (cmd_sent === 1'b1) sent_count++;

   // UART decoder: on a low TX, samples every clock of ten B-wide bits and
   // flags any bit whose level changes inside its window. Frames cut by reset
   // are discarded.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && TX === 1'b0) begin
            automatic int   st = cyc;
            automatic bit   ok = 1'b1;
            automatic bit   ab = 1'b0;
            automatic logic v = 1'b0;
            automatic logic [7:0] b = '0;
            for (int i = 0; i < 10; i++) begin
               for (int j = 0; j < B; j++) begin
                  if (!(i == 0 && j == 0)) @(negedge clk);
                  if (rst_n !== 1'b1) begin ab = 1'b1; break; end
                  if (j == 0) v = TX;
                  else if (TX !== v) ok = 1'b0;
               end
               if (ab) break;
               if (i >= 1 && i <= 8) b[i-1] = v;
               if (i == 0 && v !== 1'b0) ok = 1'b0;
               if (i == 9 && v !== 1'b1) ok = 1'b0;
            end
            if (!ab) begin
               tx_seen.push_back(b);
               tx_good.push_back(ok);
               tx_start.push_back(st);
            end
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic pulse_snd(input logic [7:0] c, input logic [15:0] d, input bit accept, output int t0);
      @(posedge clk); #1;
      cmd = c; data = d; snd_cmd = 1'b1; t0 = cyc;
      if (accept) begin
         tx_exp.push_back(c);
         tx_exp.push_back(d[15:8]);
         tx_exp.push_back(d[7:0]);
      end
      @(posedge clk); #1;
      snd_cmd = 1'b0;
   endtask

   task automatic drive_rx(input logic [7:0] b, output int s);
      logic [9:0] fr;
      fr = {1'b1, b, 1'b0};
      rx_exp.push_back(b);
      @(posedge clk); #1;
      s = cyc;
      for (int i = 0; i < 10; i++) begin
         RX = fr[i];
         repeat (B) @(posedge clk);
         #1;
      end
      RX = 1'b1;
   endtask

   task automatic wait_sent(input int budget, output bit got, output int at, output int busy_bad);
      got = 1'b0; at = 0; busy_bad = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (cmd_sent === 1'b1) begin
            got = 1'b1; at = cyc;
            if (busy !== 1'b0) busy_bad++;
            break;
         end
         if (busy !== 1'b1) busy_bad++;
      end
   endtask

   task automatic wait_rdy(input int budget, output bit got, output int at);
      got = 1'b0; at = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (resp_rdy === 1'b1) begin got = 1'b1; at = cyc; break; end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (TX !== 1'b1 || busy !== 1'b0 || cmd_sent !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_tx: TX=%b busy=%b cmd_sent=%b, required 1 0 0", TX, busy, cmd_sent);
      end
      checks++;
      if (resp !== 8'h00 || resp_rdy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_rx: resp=%h resp_rdy=%b, required 00 0", resp, resp_rdy);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
   endtask

   task automatic test_tx_basic;
      int t0, at, bb, sc0, st, prev, n;
      bit got, ok;
      logic [7:0] e, g;
      sc0 = sent_count;
      pulse_snd(8'h02, 16'h1234, 1'b1, t0);
      wait_sent(600, got, at, bb);
      checks++;
      if (!got) begin failures++; $display("[TB] FAIL basic_sent: no cmd_sent within 600 clocks"); end
      checks++;
      if (got && (at - t0 < 483 || at - t0 > 485)) begin
         failures++; $display("[TB] FAIL basic_latency: got %0d clocks, required 484+-1", at - t0);
      end
      checks++;
      if (bb != 0) begin failures++; $display("[TB] FAIL basic_busy: %0d bad busy samples, required 0", bb); end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || sent_count - sc0 != 1) begin
         failures++; $display("[TB] FAIL basic_after: busy=%b pulses=%0d, required 0 1", busy, sent_count - sc0);
      end
      n = 0; prev = 0;
      while (tx_exp.size() > 0) begin
         e = tx_exp.pop_front();
         checks++;
         if (tx_seen.size() == 0) begin
            failures++; $display("[TB] FAIL basic_byte%0d: got none, required %h", n, e);
         end else begin
            g = tx_seen.pop_front(); ok = tx_good.pop_front(); st = tx_start.pop_front();
            if (g !== e || !ok) begin
               failures++; $display("[TB] FAIL basic_byte%0d: got %h ok=%b, required %h ok=1", n, g, ok, e);
            end
            checks++;
            if ((n == 0 && st - t0 != 2) || (n > 0 && st - prev != 10*B + 1)) begin
               failures++; $display("[TB] FAIL basic_start%0d: got offset %0d, required %0d", n,
                                    (n == 0) ? st - t0 : st - prev, (n == 0) ? 2 : 10*B + 1);
            end
            prev = st;
         end
         n++;
      end
   endtask

   task automatic test_ignore_busy;
      int t0, td, at, bb, sc0, n;
      bit got, ok;
      logic [7:0] e, g;
      sc0 = sent_count;
      pulse_snd(8'h02, 16'h1234, 1'b1, t0);
      while (cyc < t0 + 99) @(posedge clk);
      pulse_snd(8'hFF, 16'hFFFF, 1'b0, td);
      wait_sent(600, got, at, bb);
      checks++;
      if (!got) begin failures++; $display("[TB] FAIL busy_sent: no cmd_sent within budget"); end
      repeat (250) @(negedge clk);
      checks++;
      if (sent_count - sc0 != 1) begin
         failures++; $display("[TB] FAIL busy_pulses: got %0d, required 1", sent_count - sc0);
      end
      n = 0;
      while (tx_exp.size() > 0) begin
         e = tx_exp.pop_front();
         checks++;
         if (tx_seen.size() == 0) begin
            failures++; $display("[TB] FAIL busy_byte%0d: got none, required %h", n, e);
         end else begin
            g = tx_seen.pop_front(); ok = tx_good.pop_front(); void'(tx_start.pop_front());
            if (g !== e || !ok) begin
               failures++; $display("[TB] FAIL busy_byte%0d: got %h ok=%b, required %h ok=1", n, g, ok, e);
            end
         end
         n++;
      end
      checks++;
      if (tx_seen.size() != 0) begin
         failures++; $display("[TB] FAIL busy_extra: got %0d extra frames, required 0", tx_seen.size());
      end
      tx_seen.delete(); tx_good.delete(); tx_start.delete();
   endtask

   task automatic test_rx_basic;
      int s, at;
      bit got;
      logic [7:0] e;
      fork
         drive_rx(8'hA5, s);
         wait_rdy(400, got, at);
      join
      e = rx_exp.pop_front();
      checks++;
      if (!got || resp !== e) begin
         failures++; $display("[TB] FAIL rx_byte: got %h rdy=%b, required %h rdy=1", resp, got, e);
      end
      checks++;
      if (got && (at - s < 150 || at - s > 160)) begin
         failures++; $display("[TB] FAIL rx_time: got %0d clocks, required 150..160", at - s);
      end
      @(posedge clk); #1; clr_resp_rdy = 1'b1;
      @(posedge clk); #1; clr_resp_rdy = 1'b0;
      @(negedge clk);
      checks++;
      if (resp_rdy !== 1'b0 || resp !== 8'hA5) begin
         failures++; $display("[TB] FAIL rx_clear: resp_rdy=%b resp=%h, required 0 a5", resp_rdy, resp);
      end
   endtask

   task automatic test_rx_glitch;
      int s, at;
      bit got;
      logic [7:0] e;
      @(posedge clk); #1; RX = 1'b0;
      repeat (3) @(posedge clk);
      #1; RX = 1'b1;
      repeat (40) @(negedge clk);
      checks++;
      if (resp_rdy !== 1'b0 || resp !== 8'hA5) begin
         failures++; $display("[TB] FAIL glitch: resp_rdy=%b resp=%h, required 0 a5", resp_rdy, resp);
      end
      fork
         drive_rx(8'h3C, s);
         wait_rdy(400, got, at);
      join
      e = rx_exp.pop_front();
      checks++;
      if (!got || resp !== e) begin
         failures++; $display("[TB] FAIL glitch_next: got %h rdy=%b, required %h rdy=1", resp, got, e);
      end
   endtask

   task automatic test_full_duplex;
      int t0, s, at, ar, bb, n;
      bit got, gr, ok;
      logic [7:0] e, g;
      fork
         begin
            pulse_snd(8'h05, 16'h0000, 1'b1, t0);
            checks++;
            if (resp_rdy !== 1'b0) begin
               failures++; $display("[TB] FAIL snd_clears_rdy: got %b, required 0", resp_rdy);
            end
         end
         begin
            repeat (3) @(posedge clk);
            fork
               drive_rx(8'h0A, s);
               wait_rdy(400, gr, ar);
            join
         end
      join
      e = rx_exp.pop_front();
      checks++;
      if (!gr || resp !== e) begin
         failures++; $display("[TB] FAIL duplex_rx: got %h rdy=%b, required %h rdy=1", resp, gr, e);
      end
      wait_sent(600, got, at, bb);
      checks++;
      if (!got || at - t0 < 483 || at - t0 > 485) begin
         failures++; $display("[TB] FAIL duplex_sent: got=%b latency %0d, required 1 484+-1", got, at - t0);
      end
      n = 0;
      while (tx_exp.size() > 0) begin
         e = tx_exp.pop_front();
         checks++;
         if (tx_seen.size() == 0) begin
            failures++; $display("[TB] FAIL duplex_byte%0d: got none, required %h", n, e);
         end else begin
            g = tx_seen.pop_front(); ok = tx_good.pop_front(); void'(tx_start.pop_front());
            if (g !== e || !ok) begin
               failures++; $display("[TB] FAIL duplex_byte%0d: got %h ok=%b, required %h ok=1", n, g, ok, e);
            end
         end
         n++;
      end
   endtask

   task automatic test_reset_abort;
      int t0, at, bb, sc0, n;
      bit got, ok;
      logic [7:0] e, g;
      pulse_snd(8'h07, 16'h8899, 1'b0, t0);
      tx_exp.push_back(8'h07);
      while (cyc < t0 + 243) @(posedge clk);
      #1; rst_n = 1'b0;
      #1;
      checks++;
      if (TX !== 1'b1 || busy !== 1'b0) begin
         failures++; $display("[TB] FAIL abort_now: TX=%b busy=%b, required 1 0", TX, busy);
      end
      sc0 = sent_count;
      repeat (3) @(posedge clk);
      #1; rst_n = 1'b1;
      repeat (400) @(negedge clk);
      checks++;
      if (sent_count != sc0 || TX !== 1'b1) begin
         failures++; $display("[TB] FAIL abort_quiet: pulses=%0d TX=%b, required 0 1", sent_count - sc0, TX);
      end
      pulse_snd(8'h06, 16'hABCD, 1'b1, t0);
      wait_sent(600, got, at, bb);
      checks++;
      if (!got || at - t0 < 483 || at - t0 > 485 || bb != 0) begin
         failures++; $display("[TB] FAIL abort_resend: got=%b latency %0d busy_bad=%0d, required 1 484+-1 0",
                              got, at - t0, bb);
      end
      n = 0;
      while (tx_exp.size() > 0) begin
         e = tx_exp.pop_front();
         checks++;
         if (tx_seen.size() == 0) begin
            failures++; $display("[TB] FAIL abort_byte%0d: got none, required %h", n, e);
         end else begin
            g = tx_seen.pop_front(); ok = tx_good.pop_front(); void'(tx_start.pop_front());
            if (g !== e || !ok) begin
               failures++; $display("[TB] FAIL abort_byte%0d: got %h ok=%b, required %h ok=1", n, g, ok, e);
            end
         end
         n++;
      end
      checks++;
      if (tx_seen.size() != 0) begin
         failures++; $display("[TB] FAIL abort_extra: got %0d extra frames, required 0", tx_seen.size());
      end
   endtask

   initial begin
      $display("[TB] remote_comm bench start, BAUD_DIV=%0d", B);
      test_reset();
      test_tx_basic();
      test_ignore_busy();
      test_rx_basic();
      test_rx_glitch();
      test_full_duplex();
      test_reset_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
